bit_op_sequencer: RTL

Command front-end for the 32-bit bit-manipulation execution unit (`int_calc_16`). It accepts bit-operation commands over a valid/ready handshake and buffers them in a small FIFO. Each legal command is issued to the execution unit as a one-cycle enable pulse with stable operands. The unit's result is captured after a fixed latency and returned over a valid/ready response channel; illegal commands are rejected without being issued.

---
 rtl/bit_op_pkg.sv | 38 +++
 rtl/bit_op_cmd_fifo.sv | 66 ++++++
 rtl/bit_op_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bit_op_pkg.sv
// Shared definitions for the bit-operation sequencer and execution unit.
// Holds the opcode constants, the sequencer FSM state type and the
// command legality check.
package bit_op_pkg;

    localparam int unsigned OP_W      = 3;
    // Widest bit-index operand is_legal() can judge; DATA_W must not exceed it.
    localparam int unsigned OPB_MAX_W = 64;

    localparam logic [OP_W-1:0] OP_CLR  = 3'b000;
    localparam logic [OP_W-1:0] OP_SET  = 3'b001;
    localparam logic [OP_W-1:0] OP_GET  = 3'b010;
    localparam logic [OP_W-1:0] OP_PASS = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Opcodes 1xx are illegal; CLR/SET/GET also need a bit index below data_w.
    // PASS does not use its index, so any value is accepted.
    function automatic logic is_legal(
        input logic [OP_W-1:0]      op,
        input logic [OPB_MAX_W-1:0] opb,
        input int unsigned          data_w
    );
        if (op[OP_W-1]) begin
            return 1'b0;
        end
        if (op == OP_PASS) begin
            return 1'b1;
        end
        return opb < OPB_MAX_W'(data_w);
    endfunction

endpackage

// File: rtl/bit_op_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and entry; ignored when full
//   pop               read request; ignored when empty
//   pop_data          current head entry (valid while !empty)
//   full, empty       occupancy flags decoded from the registered count
module bit_op_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bit_op_sequencer.sv
// Command front-end for the bit-manipulation execution unit. Buffers
// commands, issues legal ones one at a time as a single-cycle enable with
// registered operands, captures the result after LAT cycles and returns it
// on a valid/ready response channel. Illegal commands are answered with
// rsp_err=1 and never reach the unit.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_opa, cmd_opb       opcode, data operand, bit index
//   exe_enable                     one-cycle issue pulse
//   exe_operation, exe_opa/opb     issued command, held until next issue
//   exe_out, exe_sign              execution-unit result and sign flag
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_sign, rsp_op     captured result (zeroed on error) and opcode
//   rsp_err                        command was illegal, not issued
//   busy                           queued work or FSM not idle
module bit_op_sequencer
    import bit_op_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_opa,
    input  logic [DATA_W-1:0] cmd_opb,
    output logic              exe_enable,
    output logic [OP_W-1:0]   exe_operation,
    output logic [DATA_W-1:0] exe_opa,
    output logic [DATA_W-1:0] exe_opb,
    input  logic [DATA_W-1:0] exe_out,
    input  logic              exe_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_sign,
    output logic [OP_W-1:0]   rsp_op,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned ENTRY_W = OP_W + 2 * DATA_W;
    localparam int unsigned CNT_W   = $clog2(LAT + 1);

    state_t             state;
    logic [CNT_W-1:0]   lat_cnt;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [OP_W-1:0]    head_op;
    logic [DATA_W-1:0]  head_opa;
    logic [DATA_W-1:0]  head_opb;
    logic               head_legal;

    // Ready follows the registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = !fifo_full && !rst;

    bit_op_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_op, cmd_opa, cmd_opb}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_op    = fifo_head[ENTRY_W-1 -: OP_W];
    assign head_opa   = fifo_head[2*DATA_W-1 -: DATA_W];
    assign head_opb   = fifo_head[DATA_W-1:0];
    assign head_legal = is_legal(head_op, OPB_MAX_W'(head_opb), DATA_W);

    // The head is consumed only from IDLE, which keeps issue strictly serial.
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign busy     = !fifo_empty || (state != IDLE);

    // Sequencer FSM with registered execution and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            exe_enable    <= 1'b0;
            exe_operation <= '0;
            exe_opa       <= '0;
            exe_opb       <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_sign      <= 1'b0;
            rsp_op        <= '0;
            rsp_err       <= 1'b0;
        end else begin
            exe_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_legal) begin
                            exe_enable    <= 1'b1;
                            exe_operation <= head_op;
                            exe_opa       <= head_opa;
                            exe_opb       <= head_opb;
                            state         <= ISSUE;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_sign  <= 1'b0;
                            rsp_op    <= head_op;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= CNT_W'(LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    // Count reaches zero on this edge: the result is valid now.
                    if (lat_cnt == CNT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= exe_out;
                        rsp_sign  <= exe_sign;
                        rsp_op    <= exe_operation;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
